// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution / 2x2 maxpool engine.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC,
        WR0,
        PRD,
        PWR,
        DONE
    } state_t;

    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    // Identity kernel in Q.16 with zero bias, loaded on reset.
    localparam int DEF_KERN [9] = '{0, 0, 0, 0, 32'h10000, 0, 0, 0, 0};
    localparam int DEF_BIAS     = 0;

endpackage

// File: rtl/conv_mac.sv
// 9-tap multiply-accumulate with bias, round-half-up, ReLU and saturation.
module conv_mac #(
    parameter int DW   = 20,
    parameter int FRAC = 16
) (
    input  logic [8:0][DW-1:0] taps,
    input  logic [8:0][DW-1:0] kern,
    input  logic [DW-1:0]      bias,
    output logic [DW-1:0]      res
);

    localparam int AC = 2*DW + 4;
    localparam logic signed [AC-1:0] SAT  = {{(AC-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AC-1:0] HALF = AC'(1) << (FRAC-1);

    logic signed [AC-1:0] acc, px, kx, rnd, shv;

    always_comb begin
        px  = '0;
        kx  = '0;
        acc = AC'($signed(bias)) <<< FRAC;
        // Pixels are unsigned: a zero sign bit keeps them positive in the signed product.
        for (int unsigned i = 0; i < 9; i++) begin
            px  = AC'($signed({1'b0, taps[i]}));
            kx  = AC'($signed(kern[i]));
            acc = acc + px * kx;
        end
        rnd = acc + HALF;
        shv = rnd >>> FRAC;
        if (shv < 0)
            res = '0;
        else if (shv > SAT)
            res = SAT[DW-1:0];
        else
            res = shv[DW-1:0];
    end

endmodule

// File: rtl/conv_engine_p.sv
// Raster-order 3x3 convolution into layer L0, optionally followed by a 2x2
// maxpool pass from L0 into L1.
module conv_engine_p
    import conv_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int DW    = 20,
    parameter int FRAC  = 16,
    parameter int AW    = $clog2(IMG_W*IMG_W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ready,
    output logic          busy,
    input  logic          kwe,
    input  logic [3:0]    kaddr,
    input  logic [DW-1:0] kdata,
    input  logic          pool_en,
    output logic [AW-1:0] iaddr,
    input  logic [DW-1:0] idata,
    output logic          crd,
    output logic [AW-1:0] caddr_rd,
    input  logic [DW-1:0] cdata_rd,
    output logic          cwr,
    output logic [AW-1:0] caddr_wr,
    output logic [DW-1:0] cdata_wr,
    output logic [2:0]    csel
);

    localparam int LW = AW/2;

    state_t            state;
    logic [8:0][DW-1:0] kern, taps;
    logic [DW-1:0]     bias, mac_res, mx, pmax;
    logic [3:0]        tap;
    logic [AW-1:0]     pix;
    logic [AW-3:0]     pblk;
    logic [1:0]        pk;
    logic              pool_q;
    logic [AW:0]       cur_ta, nxt_ta, first_ta;

    // MSB flags a tap outside the image; the address then falls back to the
    // centre pixel so the bus never leaves the image.
    function automatic logic [AW:0] tap_addr(input logic [AW-1:0] p, input logic [3:0] k);
        int r, c;
        r = int'(p[AW-1:LW]) + int'(k / 4'd3) - 1;
        c = int'(p[LW-1:0]) + int'(k % 4'd3) - 1;
        if (r < 0 || r >= IMG_W || c < 0 || c >= IMG_W)
            return {1'b1, p};
        return {1'b0, r[LW-1:0], c[LW-1:0]};
    endfunction

    function automatic logic [AW-1:0] pool_addr(input logic [AW-3:0] b, input logic [1:0] q);
        return {b[AW-3:LW-1], q[1], b[LW-2:0], q[0]};
    endfunction

    always_comb begin
        cur_ta   = tap_addr(pix, tap);
        nxt_ta   = tap_addr(pix, tap + 4'd1);
        first_ta = tap_addr(pix + 1'b1, 4'd0);
        pmax     = (cdata_rd > mx) ? cdata_rd : mx;
    end

    conv_mac #(.DW(DW), .FRAC(FRAC)) u_mac (
        .taps (taps),
        .kern (kern),
        .bias (bias),
        .res  (mac_res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 9; i++)
                kern[i] <= DW'(DEF_KERN[i]);
            bias <= DW'(DEF_BIAS);
        end else if (kwe && !busy) begin
            if (kaddr < 4'd9)
                kern[kaddr] <= kdata;
            else if (kaddr == 4'd9)
                bias <= kdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            crd      <= 1'b0;
            cwr      <= 1'b0;
            csel     <= CSEL_NONE;
            iaddr    <= '0;
            caddr_rd <= '0;
            caddr_wr <= '0;
            cdata_wr <= '0;
            tap      <= '0;
            pix      <= '0;
            pblk     <= '0;
            pk       <= '0;
            mx       <= '0;
            pool_q   <= 1'b0;
            taps     <= '0;
        end else begin
            case (state)
                IDLE: if (ready) begin
                    state  <= FETCH;
                    busy   <= 1'b1;
                    pool_q <= pool_en;
                    pix    <= '0;
                    tap    <= '0;
                    iaddr  <= '0;  // tap 0 of pixel 0 is padding; centre address is 0
                end
                FETCH: begin
                    taps[tap] <= cur_ta[AW] ? '0 : idata;
                    if (tap == 4'd8) begin
                        state <= MAC;
                    end else begin
                        tap   <= tap + 4'd1;
                        iaddr <= nxt_ta[AW-1:0];
                    end
                end
                MAC: begin
                    cwr      <= 1'b1;
                    csel     <= CSEL_L0;
                    caddr_wr <= pix;
                    cdata_wr <= mac_res;
                    state    <= WR0;
                end
                WR0: begin
                    cwr  <= 1'b0;
                    csel <= CSEL_NONE;
                    if (pix == '1) begin
                        if (pool_q) begin
                            state    <= PRD;
                            crd      <= 1'b1;
                            csel     <= CSEL_L0;
                            pblk     <= '0;
                            pk       <= '0;
                            caddr_rd <= '0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        pix   <= pix + 1'b1;
                        tap   <= '0;
                        iaddr <= first_ta[AW-1:0];
                        state <= FETCH;
                    end
                end
                PRD: begin
                    mx <= (pk == 2'd0) ? cdata_rd : pmax;
                    if (pk == 2'd3) begin
                        crd      <= 1'b0;
                        cwr      <= 1'b1;
                        csel     <= CSEL_L1;
                        caddr_wr <= AW'(pblk);
                        cdata_wr <= pmax;
                        state    <= PWR;
                    end else begin
                        pk       <= pk + 2'd1;
                        caddr_rd <= pool_addr(pblk, pk + 2'd1);
                    end
                end
                PWR: begin
                    cwr <= 1'b0;
                    if (pblk == '1) begin
                        csel  <= CSEL_NONE;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        pblk     <= pblk + 1'b1;
                        pk       <= '0;
                        crd      <= 1'b1;
                        csel     <= CSEL_L0;
                        caddr_rd <= pool_addr(pblk + 1'b1, 2'd0);
                        state    <= PRD;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
